// File: rtl/true_dpr.sv
// true_dpr: true dual-port synchronous RAM, two independent read/write ports
// (A and B) on one clock, registered read data with one cycle of latency.
//
// Ports:
//   clk, rst_n             clock; asynchronous active-low reset (clears dout only)
//   en_a, we_a             port A enable and write enable (we qualified by en)
//   addr_a, din_a, dout_a  port A address, write data, registered read data
//   en_b, we_b             port B enable and write enable
//   addr_b, din_b, dout_b  port B address, write data, registered read data
//
// Collisions: when both ports write the same word, port A's data is stored.
// A read of a word being written by the other port returns the old contents.
module true_dpr #(
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_SIZE  = 8,
  parameter int RAM_SIZE   = 1 << ADDR_SIZE,
  parameter int WRITE_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_a,
  input  logic                 we_a,
  input  logic [ADDR_SIZE-1:0] addr_a,
  input  logic [DATA_SIZE-1:0] din_a,
  output logic [DATA_SIZE-1:0] dout_a,
  input  logic                 en_b,
  input  logic                 we_b,
  input  logic [ADDR_SIZE-1:0] addr_b,
  input  logic [DATA_SIZE-1:0] din_b,
  output logic [DATA_SIZE-1:0] dout_b
);

  // One extra bit so RAM_SIZE == 2^ADDR_SIZE is representable.
  localparam logic [ADDR_SIZE:0] RAM_SIZE_W = (ADDR_SIZE + 1)'(RAM_SIZE);

  logic [DATA_SIZE-1:0] mem [RAM_SIZE];

  logic                 in_range_a, in_range_b;
  logic                 wr_a, wr_b;
  logic [DATA_SIZE-1:0] rd_a, rd_b;
  logic [DATA_SIZE-1:0] dout_a_d, dout_a_q;
  logic [DATA_SIZE-1:0] dout_b_d, dout_b_q;

  always_comb begin
    in_range_a = ({1'b0, addr_a} < RAM_SIZE_W);
    in_range_b = ({1'b0, addr_b} < RAM_SIZE_W);
    wr_a       = en_a && we_a && in_range_a;
    wr_b       = en_b && we_b && in_range_b;
    // Array contents before this edge's writes; out-of-range reads return 0.
    rd_a       = in_range_a ? mem[addr_a] : '0;
    rd_b       = in_range_b ? mem[addr_b] : '0;
  end

  always_comb begin
    dout_a_d = dout_a_q;
    if (en_a) begin
      if (we_a && (WRITE_MODE == 0)) dout_a_d = din_a;
      else                           dout_a_d = rd_a;
    end
  end

  always_comb begin
    dout_b_d = dout_b_q;
    if (en_b) begin
      if (we_b && (WRITE_MODE == 0)) dout_b_d = din_b;
      else                           dout_b_d = rd_b;
    end
  end

  // Storage is never reset; writes are only blocked while reset is held.
  // Port B is assigned first so that port A's write wins on a shared address.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (wr_b) mem[addr_b] <= din_b;
      if (wr_a) mem[addr_a] <= din_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
    end
  end

  assign dout_a = dout_a_q;
  assign dout_b = dout_b_q;

endmodule

// File: tb/tb_true_dpr.sv
// tb_true_dpr: self-checking bench for true_dpr (default parameters,
// WRITE_MODE=0). A table of single-edge vectors with hand-derived expected
// read data is applied through a scoreboard queue, followed by a hand-written
// asynchronous-reset sequence.
module tb_true_dpr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, we_a, en_b, we_b;
  logic [7:0] addr_a, din_a, addr_b, din_b;
  logic [7:0] dout_a, dout_b;

  int n_vec  = 0;
  int n_miss = 0;

  true_dpr #(
    .ADDR_SIZE (8),
    .DATA_SIZE (8),
    .RAM_SIZE  (256),
    .WRITE_MODE(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en_a  (en_a),
    .we_a  (we_a),
    .addr_a(addr_a),
    .din_a (din_a),
    .dout_a(dout_a),
    .en_b  (en_b),
    .we_b  (we_b),
    .addr_b(addr_b),
    .din_b (din_b),
    .dout_b(dout_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en_a;
    logic       we_a;
    logic [7:0] addr_a;
    logic [7:0] din_a;
    logic       en_b;
    logic       we_b;
    logic [7:0] addr_b;
    logic [7:0] din_b;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic ea, input logic wa, input logic [7:0] aa,
                              input logic [7:0] da, input logic eb, input logic wb,
                              input logic [7:0] ab, input logic [7:0] db,
                              input logic [7:0] xa, input logic [7:0] xb,
                              input string nm);
    vec_t v;
    v.en_a = ea; v.we_a = wa; v.addr_a = aa; v.din_a = da;
    v.en_b = eb; v.we_b = wb; v.addr_b = ab; v.din_b = db;
    v.exp_a = xa; v.exp_b = xb; v.name = nm;
    return v;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ea, input logic wa, input logic [7:0] aa,
                       input logic [7:0] da, input logic eb, input logic wb,
                       input logic [7:0] ab, input logic [7:0] db);
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
  endtask

  initial begin
    //              en we addr  din    en we addr  din    exp_a  exp_b
    vecs.push_back(mk(1, 1, 8'h01, 8'hA1, 0, 0, 8'h00, 8'h00, 8'hA1, 8'h00, "a_wr_first"));
    vecs.push_back(mk(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 8'hA1, 8'h00, "a_rd_01"));
    vecs.push_back(mk(1, 1, 8'h11, 8'h5A, 0, 0, 8'h00, 8'h00, 8'h5A, 8'h00, "a_preload_11"));
    vecs.push_back(mk(0, 1, 8'h11, 8'h16, 1, 1, 8'h10, 8'h13, 8'h5A, 8'h13, "a_dis_b_wr"));
    vecs.push_back(mk(1, 0, 8'h11, 8'h00, 1, 0, 8'h10, 8'h00, 8'h5A, 8'h13, "rd_11_10"));
    vecs.push_back(mk(1, 1, 8'h03, 8'hCC, 1, 1, 8'h04, 8'hDD, 8'hCC, 8'hDD, "wr_03_04"));
    vecs.push_back(mk(1, 0, 8'h03, 8'h00, 1, 0, 8'h04, 8'h00, 8'hCC, 8'hDD, "rd_03_04"));
    vecs.push_back(mk(1, 1, 8'h05, 8'hEE, 1, 1, 8'h05, 8'hFF, 8'hEE, 8'hFF, "ww_collide"));
    vecs.push_back(mk(1, 0, 8'h05, 8'h00, 1, 0, 8'h05, 8'h00, 8'hEE, 8'hEE, "rd_05_a_wins"));
    vecs.push_back(mk(1, 1, 8'h06, 8'h11, 0, 0, 8'h00, 8'h00, 8'h11, 8'hEE, "preload_06"));
    vecs.push_back(mk(1, 1, 8'h06, 8'h22, 1, 0, 8'h06, 8'h00, 8'h22, 8'h11, "rw_collide"));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h06, 8'h00, 8'h22, 8'h22, "b_rd_06_new"));
    vecs.push_back(mk(1, 1, 8'h07, 8'h3C, 0, 1, 8'h07, 8'h99, 8'h3C, 8'h22, "b_dis_wr"));
    vecs.push_back(mk(1, 0, 8'h07, 8'h00, 1, 0, 8'h07, 8'h00, 8'h3C, 8'h3C, "rd_07"));
    vecs.push_back(mk(1, 0, 8'h03, 8'h00, 1, 1, 8'h08, 8'h77, 8'hCC, 8'h77, "a_rd_b_wr"));

    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    rst_n = 1'b0;
    #2;
    check("rst_dout_a", dout_a, 8'h00);
    check("rst_dout_b", dout_b, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      exp_t e;
      @(negedge clk);
      drive(vecs[i].en_a, vecs[i].we_a, vecs[i].addr_a, vecs[i].din_a,
            vecs[i].en_b, vecs[i].we_b, vecs[i].addr_b, vecs[i].din_b);
      e.exp_a = vecs[i].exp_a;
      e.exp_b = vecs[i].exp_b;
      e.name  = vecs[i].name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.name, "_a"}, dout_a, e.exp_a);
      check({e.name, "_b"}, dout_b, e.exp_b);
    end

    // Asynchronous reset between edges, with both ports requesting writes.
    @(negedge clk);
    drive(1, 1, 8'h03, 8'h55, 1, 1, 8'h08, 8'h66);
    @(posedge clk);
    #1;
    check("pre_rst_a", dout_a, 8'h55);
    check("pre_rst_b", dout_b, 8'h66);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_a", dout_a, 8'h00);
    check("async_rst_b", dout_b, 8'h00);
    drive(1, 1, 8'h03, 8'h99, 1, 1, 8'h08, 8'h88);
    @(posedge clk);
    #1;
    check("rst_held_a", dout_a, 8'h00);
    check("rst_held_b", dout_b, 8'h00);
    @(negedge clk);
    drive(1, 0, 8'h03, 8'h00, 1, 0, 8'h08, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_rd_03", dout_a, 8'h55);
    check("post_rst_rd_08", dout_b, 8'h66);

    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/true_dpr.md
Name: true_dpr

Overview:
- True dual-port synchronous RAM with two fully independent read/write ports, A and B, on a single clock.
- Each port has its own enable, write enable, address, write data and registered read data.
- Used as a shared buffer between two agents that need concurrent read or write access to one storage array.
- Defined collision rules make behaviour deterministic when both ports touch the same address.

Parameters:
- ADDR_SIZE, 8, address width of each port in bits.
- DATA_SIZE, 8, word width in bits.
- RAM_SIZE, 1 << ADDR_SIZE, number of words in the array. Legal range is 1 to 2^ADDR_SIZE.
- WRITE_MODE, 0, same-port read-during-write behaviour. 0 = write-first (dout shows din). 1 = read-first (dout shows old contents).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en_a  input  1  port A enable; when 0, port A neither reads nor writes.
- we_a  input  1  port A write enable; qualified by en_a.
- addr_a  input  ADDR_SIZE  port A word address.
- din_a  input  DATA_SIZE  port A write data.
- dout_a  output  DATA_SIZE  port A registered read data.
- en_b  input  1  port B enable.
- we_b  input  1  port B write enable; qualified by en_b.
- addr_b  input  ADDR_SIZE  port B word address.
- din_b  input  DATA_SIZE  port B write data.
- dout_b  output  DATA_SIZE  port B registered read data.

Behaviour:
- Reset: one clock (clk). rst_n is asynchronous and active-low.
  - rst_n low immediately forces dout_a and dout_b to 0. They stay 0 while rst_n is low.
  - Memory contents are not reset; a write accepted before reset is still readable after rst_n deasserts.
  - Ports ignore en/we while rst_n is low.
- Write: on a rising edge with en_x=1, we_x=1 and addr_x < RAM_SIZE, mem[addr_x] <= din_x.
- Read latency is 1 cycle.
  - On a rising edge with en_x=1 and we_x=0, dout_x <= mem[addr_x] (value before this edge's writes).
  - The read value is visible after that edge.
- Same-port write:
  - WRITE_MODE=0: dout_x <= din_x.
  - WRITE_MODE=1: dout_x <= old mem[addr_x].
- Disabled port: en_x=0 means no write, even if we_x=1, and dout_x holds its previous value.
- Out-of-range address (addr_x >= RAM_SIZE): writes are dropped and reads load 0. Only possible when RAM_SIZE < 2^ADDR_SIZE.
- Write/write collision: both ports write the same address on the same edge. Port A wins, so mem takes din_a. Each port's dout follows its own WRITE_MODE rule using its own din.
- Cross-port read/write collision: one port reads an address the other writes on the same edge. The reader gets the old contents; the new value is readable from the next edge.
- Different addresses: both ports operate fully independently every cycle, with no stalls and no handshake.
- Uninitialised locations read as X in simulation; the bench reads only written locations.

Test Plan:
1. Port A write/read. Assert and release reset. Set en_a=1, we_a=1, addr_a=0x01, din_a=0xA1 for one edge; next cycle we_a=0, addr_a=0x01. Required: dout_a=0xA1 after the read edge, and dout_a=0xA1 on the write edge (WRITE_MODE=0).
2. Disabled port A with port B write. Set en_a=0, we_a=1, addr_a=0x11, din_a=0x16; en_b=1, we_b=1, addr_b=0x10, din_b=0x13. Then read both ports with en=1. Required: dout_b=0x13, mem[0x11] unchanged (previously written value, e.g. 0x00), and dout_a held while disabled.
3. Concurrent writes to different addresses. Same edge: A writes 0x03<=0xCC, B writes 0x04<=0xDD; next edge read A@0x03, B@0x04. Required: dout_a=0xCC, dout_b=0xDD.
4. Write/write collision. Same edge: A writes 0x05<=0xEE, B writes 0x05<=0xFF; next edge both read 0x05. Required: dout_a=dout_b=0xEE.
5. Cross-port collision. Preload 0x06=0x11. Same edge: A writes 0x06<=0x22, B reads 0x06. Required: dout_b=0x11; the following B read gives 0x22.
6. Reset mid-operation. With dout_a=0xCC, pull rst_n low between edges. Required: dout_a=dout_b=0 immediately, without waiting for a clock edge. After release, reading 0x03 gives 0xCC.
